rx_decoder: RTL and testbench

RX_DECODER -- requirements
Module: rx_decoder

---
 rtl/rx_decoder_pkg.sv | 37 +++
 rtl/rx_unstuff.sv | 66 ++++++
 rtl/rx_decoder.sv | 165 ++++++++++++++++
 tb/tb_rx_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package : types
//  Shared line-symbol and receiver-state types for the low-speed receive path.
//    d_port_t   : retimed line symbol (SE0, J, K, SE1)
//    rx_state_t : receive state machine states
//  Revision : 1.0  initial release
// ============================================================================
package types;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ABORT = 3'd4
  } rx_state_t;

  // Run of decoded ones after which the next bit is a stuffed bit.
  localparam int unsigned ONES_LIMIT  = 6;
  // Consecutive J samples needed to leave ABORT.
  localparam int unsigned ABORT_J_LEN = 8;

  // True for the two differential data symbols.
  function automatic logic is_jk(input d_port_t s);
    return (s == J) || (s == K);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_unstuff.sv
`default_nettype none
// ============================================================================
//  Module  : rx_unstuff
//  NRZI decoder and bit unstuffer.
//    clk, reset   : clock, synchronous active-high reset
//    i_strobe     : bit-centre strobe; all state advances only on strobe
//    i_q          : retimed line symbol
//    i_count_en   : ones-run tracking active (SYNC and DATA)
//    o_bit        : NRZI-decoded bit of i_q (1 = no transition)
//    o_bit_valid  : decoded data bit is real (not a stuffed bit)
//    o_stuff_err  : stuffed bit decoded as 1 (only with RX_STUFF_CHECK_EN)
//  Configuration macro: RX_STUFF_CHECK_EN
//  Revision : 1.0  initial release
// ============================================================================
module rx_unstuff
  import types::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_strobe,
  input  d_port_t i_q,
  input  logic    i_count_en,
  output logic    o_bit,
  output logic    o_bit_valid,
  output logic    o_stuff_err
);

  d_port_t    r_prev;
  logic [2:0] r_ones;

  logic w_bit;
  logic w_jk;
  logic w_stuff_slot;

  assign w_bit        = (i_q == r_prev);
  assign w_jk         = is_jk(i_q);
  assign w_stuff_slot = (r_ones == 3'(ONES_LIMIT));

  assign o_bit       = w_bit;
  assign o_bit_valid = i_strobe & i_count_en & w_jk & ~w_stuff_slot;
`ifdef RX_STUFF_CHECK_EN
  assign o_stuff_err = i_strobe & i_count_en & w_jk & w_stuff_slot & w_bit;
`else
  assign o_stuff_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= J;
      r_ones <= 3'd0;
    end else if (i_strobe) begin
      r_prev <= i_q;
      // The stuffed slot itself, any non-data symbol, or leaving the
      // packet all restart the run.
      if (!i_count_en || !w_jk || w_stuff_slot) begin
        r_ones <= 3'd0;
      end else if (w_bit) begin
        r_ones <= r_ones + 3'd1;
      end else begin
        r_ones <= 3'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : rx_decoder
//  Packet receive state machine and byte assembly on top of rx_unstuff.
//    clk, reset : 24 MHz clock, synchronous active-high reset
//    q          : retimed line symbol
//    strobe     : one-cycle bit-centre strobe
//    rx_data    : received byte, LSB first on the line
//    rx_valid   : one-cycle pulse, rx_data valid
//    rx_active  : high from SYNC completion to packet end or abort
//    rx_error   : one-cycle pulse on stuff, framing or SE1 error
//    eop        : one-cycle pulse on valid end of packet
//  Configuration macro: RX_STUFF_CHECK_EN (stuff errors abort the packet)
//  Revision : 1.0  initial release
// ============================================================================
module rx_decoder
  import types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    q,
  input  logic       strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic       eop
);

  rx_state_t  r_state,  w_state_nx;
  logic [7:0] r_data,   w_data_nx;
  logic [2:0] r_bitcnt, w_bitcnt_nx;
  logic [2:0] r_jcnt,   w_jcnt_nx;
  logic       r_valid,  w_valid_nx;
  logic       r_active, w_active_nx;
  logic       r_error,  w_error_nx;
  logic       r_eop,    w_eop_nx;

  logic w_bit;
  logic w_bit_valid;
  logic w_stuff_err;
  logic w_count_en;

  assign w_count_en = (r_state == SYNC) || (r_state == DATA);

  rx_unstuff u_unstuff (
    .clk         (clk),
    .reset       (reset),
    .i_strobe    (strobe),
    .i_q         (q),
    .i_count_en  (w_count_en),
    .o_bit       (w_bit),
    .o_bit_valid (w_bit_valid),
    .o_stuff_err (w_stuff_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_data   <= 8'h00;
      r_bitcnt <= 3'd0;
      r_jcnt   <= 3'd0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_error  <= 1'b0;
      r_eop    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_data   <= w_data_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_jcnt   <= w_jcnt_nx;
      r_valid  <= w_valid_nx;
      r_active <= w_active_nx;
      r_error  <= w_error_nx;
      r_eop    <= w_eop_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_data_nx   = r_data;
    w_bitcnt_nx = r_bitcnt;
    w_jcnt_nx   = r_jcnt;
    w_active_nx = r_active;
    w_valid_nx  = 1'b0;
    w_error_nx  = 1'b0;
    w_eop_nx    = 1'b0;

    if (strobe) begin
      unique case (r_state)
        IDLE: begin
          if (q == K) w_state_nx = SYNC;
        end

        SYNC: begin
          if (q == SE1) begin
            w_state_nx = ABORT;
            w_error_nx = 1'b1;
            w_jcnt_nx  = 3'd0;
          end else if (q == SE0) begin
            w_state_nx = IDLE;
          end else if (w_bit) begin
            // Closing K,K of SYNC; the unstuffer has already counted it as a one.
            w_state_nx  = DATA;
            w_active_nx = 1'b1;
            w_bitcnt_nx = 3'd0;
          end
        end

        DATA: begin
          if ((q == SE1) || w_stuff_err) begin
            w_state_nx  = ABORT;
            w_error_nx  = 1'b1;
            w_active_nx = 1'b0;
            w_jcnt_nx   = 3'd0;
          end else if (q == SE0) begin
            w_state_nx = EOP;
            w_error_nx = (r_bitcnt != 3'd0);
          end else if (w_bit_valid) begin
            w_data_nx   = {w_bit, r_data[7:1]};
            w_bitcnt_nx = r_bitcnt + 3'd1;
            w_valid_nx  = (r_bitcnt == 3'd7);
          end
        end

        EOP: begin
          if (q == J) begin
            w_state_nx  = IDLE;
            w_eop_nx    = 1'b1;
            w_active_nx = 1'b0;
          end else if (q != SE0) begin
            w_state_nx  = ABORT;
            w_error_nx  = 1'b1;
            w_active_nx = 1'b0;
            w_jcnt_nx   = 3'd0;
          end
        end

        ABORT: begin
          w_active_nx = 1'b0;
          if (q == J) begin
            if (r_jcnt == 3'(ABORT_J_LEN - 1)) begin
              w_state_nx = IDLE;
              w_jcnt_nx  = 3'd0;
            end else begin
              w_jcnt_nx = r_jcnt + 3'd1;
            end
          end else begin
            w_jcnt_nx = 3'd0;
          end
        end

        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_active = r_active;
  assign rx_error  = r_error;
  assign eop       = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rx_decoder
//  Self-checking bench for rx_decoder. A transmit-side model NRZI-encodes and
//  bit-stuffs packets; expected receive events go into a scoreboard queue and
//  a monitor compares every rx_valid / rx_error / eop pulse against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_decoder;
  import types::*;

  logic       clk = 1'b0;
  logic       reset;
  d_port_t    q;
  logic       strobe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       eop;

  rx_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .strobe    (strobe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error),
    .eop       (eop)
  );

  always #21 clk = ~clk;

  localparam logic [1:0] EV_VALID = 2'd0;
  localparam logic [1:0] EV_ERR   = 2'd1;
  localparam logic [1:0] EV_EOP   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  d_port_t last_sym = J;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rx_valid || rx_error || eop) begin
      exp_t e;
      logic [1:0] kind;
      n_checks++;
      kind = rx_valid ? EV_VALID : (rx_error ? EV_ERR : EV_EOP);
      if ((int'(rx_valid) + int'(rx_error) + int'(eop)) > 1) begin
        n_fail++;
        $display("FAIL coincident_pulses: valid=%0b error=%0b eop=%0b required at most one",
                 rx_valid, rx_error, eop);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: kind=%0d data=%02h required no event", kind, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || (kind == EV_VALID && e.data != rx_data)) begin
          n_fail++;
          $display("FAIL event: actual kind=%0d data=%02h required kind=%0d data=%02h",
                   kind, rx_data, e.kind, e.data);
        end
      end
    end
  end

  // One symbol per 16-cycle bit period, strobed for one cycle.
  task automatic tick_sym(input d_port_t s);
    @(posedge clk);
    #1;
    q      = s;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    repeat (14) @(posedge clk);
    last_sym = s;
  endtask

  // NRZI: 1 keeps the line level, 0 toggles it.
  task automatic raw_bit(input logic b);
    d_port_t s;
    s = b ? last_sym : ((last_sym == J) ? K : J);
    tick_sym(s);
  endtask

  // Transmit rule: after six consecutive ones a 0 is inserted.
  task automatic stuffed_bit(input logic b, inout int run);
    raw_bit(b);
    run = b ? run + 1 : 0;
    if (run == 6) begin
      raw_bit(1'b0);
      run = 0;
    end
  endtask

  task automatic send_sync();
    tick_sym(K); tick_sym(J); tick_sym(K); tick_sym(J);
    tick_sym(K); tick_sym(J); tick_sym(K); tick_sym(K);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit exp_en, inout int run);
    if (exp_en) push_exp(EV_VALID, d);
    for (int i = 0; i < 8; i++) stuffed_bit(d[i], run);
  endtask

  task automatic send_eop(input bit exp_en);
    if (exp_en) push_exp(EV_EOP, 8'h00);
    tick_sym(SE0);
    tick_sym(SE0);
    tick_sym(J);
  endtask

  task automatic send_packet(input logic [7:0] bytes [4], input int n, input bit exp_en);
    int run;
    send_sync();
    run = 1;  // closing K,K of SYNC is the first one of the run
    for (int i = 0; i < n; i++) send_byte(bytes[i], exp_en, run);
    send_eop(exp_en);
  endtask

  initial begin
    #(90000 * 42);
    $display("FAIL watchdog: simulation time limit reached, %0d events outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt [4];
    int run;

    reset  = 1'b1;
    strobe = 1'b0;
    q      = J;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data",   int'(rx_data),   0);
    check("reset_rx_valid",  int'(rx_valid),  0);
    check("reset_rx_active", int'(rx_active), 0);
    check("reset_rx_error",  int'(rx_error),  0);
    check("reset_eop",       int'(eop),       0);
    reset = 1'b0;

    // Single A5 packet, watching rx_active around SYNC completion.
    repeat (3) tick_sym(J);
    tick_sym(K); tick_sym(J); tick_sym(K); tick_sym(J);
    tick_sym(K); tick_sym(J); tick_sym(K);
    check("sync_active_before", int'(rx_active), 0);
    tick_sym(K);
    check("sync_active_after", int'(rx_active), 1);
    run = 1;
    send_byte(8'hA5, 1'b1, run);
    send_eop(1'b1);
    check("a5_active_end", int'(rx_active), 0);

    // All-ones byte exercises the inserted 0 after the sixth one.
    pkt[0] = 8'hFF; pkt[1] = 8'h7E;
    repeat (2) tick_sym(J);
    send_packet(pkt, 2, 1'b1);
    check("ff_last_data", int'(rx_data), 'h7E);

    // Seven line ones in DATA with no stuffed 0, then two zeros.
    repeat (2) tick_sym(J);
    send_sync();
`ifdef RX_STUFF_CHECK_EN
    push_exp(EV_ERR, 8'h00);
`else
    push_exp(EV_VALID, 8'h3F);
    push_exp(EV_EOP, 8'h00);
`endif
    repeat (7) raw_bit(1'b1);
    raw_bit(1'b0);
    raw_bit(1'b0);
    tick_sym(SE0); tick_sym(SE0); tick_sym(J);
    repeat (8) tick_sym(J);
    check("seven_ones_active", int'(rx_active), 0);

    // Truncated byte: SE0 after five data bits.
    repeat (2) tick_sym(J);
    send_sync();
    run = 1;
    for (int i = 0; i < 5; i++) stuffed_bit(1'(i & 1), run);
    push_exp(EV_ERR, 8'h00);
    tick_sym(SE0);
    check("trunc_active_in_eop", int'(rx_active), 1);
    push_exp(EV_EOP, 8'h00);
    tick_sym(SE0);
    tick_sym(J);
    check("trunc_active_end", int'(rx_active), 0);

    // Reset together with strobe during the fourth bit.
    repeat (2) tick_sym(J);
    send_sync();
    run = 1;
    for (int i = 0; i < 3; i++) stuffed_bit(1'b1, run);
    @(posedge clk);
    #1;
    q      = (last_sym == J) ? K : J;
    strobe = 1'b1;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    reset  = 1'b0;
    q      = J;
    last_sym = J;
    check("midreset_rx_data",   int'(rx_data),   0);
    check("midreset_rx_valid",  int'(rx_valid),  0);
    check("midreset_rx_active", int'(rx_active), 0);
    check("midreset_rx_error",  int'(rx_error),  0);
    check("midreset_eop",       int'(eop),       0);
    repeat (14) @(posedge clk);
    repeat (2) tick_sym(J);
    pkt[0] = 8'h3C;
    send_packet(pkt, 1, 1'b1);

    // SE1 in DATA, then ABORT exit needs eight consecutive J.
    repeat (2) tick_sym(J);
    send_sync();
    raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b1);
    push_exp(EV_ERR, 8'h00);
    tick_sym(SE1);
    check("se1_active", int'(rx_active), 0);
    repeat (5) tick_sym(J);
    tick_sym(K);
    repeat (7) tick_sym(J);
    pkt[0] = 8'hA5;
    send_packet(pkt, 1, 1'b0);  // still in ABORT: nothing expected
    check("abort_active", int'(rx_active), 0);
    repeat (8) tick_sym(J);
    pkt[0] = 8'hC3;
    send_packet(pkt, 1, 1'b1);

    // Randomised packets, some truncated mid-byte.
    for (int p = 0; p < 15; p++) begin
      int n;
      repeat ($urandom_range(1, 3)) tick_sym(J);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++)
        pkt[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(1, 7);
        send_sync();
        run = 1;
        for (int i = 0; i < n; i++) send_byte(pkt[i], 1'b1, run);
        for (int i = 0; i < k; i++) stuffed_bit(1'($urandom), run);
        push_exp(EV_ERR, 8'h00);
        send_eop(1'b1);
      end else begin
        send_packet(pkt, n, 1'b1);
      end
      check("rand_active_end", int'(rx_active), 0);
    end

    repeat (4) tick_sym(J);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
